counter_mod_updown: RTL and testbench
=====================================

# counter_mod_updown

Parametrised modulo-N up/down counter for the SDM sequential library: the next generation of the free-running 7-bit counter. It keeps the state-register / next-state / output split and adds configurable width and modulus, count direction, enable, prescaler, parallel load, synchronous clear, wrap or saturate mode, a terminal-count strobe and a sticky overflow flag. Timer, divider and sequencer blocks instantiate it wherever a bounded count is needed.

## Interface

- WIDTH, 7, width of count output q
- MOD, 128, count range 0..MOD-1; legal 2 ≤ MOD ≤ 2^WIDTH
- PRESCALE, 1, enabled cycles per count step; legal ≥ 1
- WRAP, 1, 1 = wrap at boundary, 0 = saturate at boundary
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- clr  in  1  synchronous clear of q, prescaler and ovf
- load  in  1  parallel load of d into q
- d  in  WIDTH  load value
- en  in  1  count enable
- up  in  1  direction: 1 = increment, 0 = decrement
- q  out  WIDTH  current count (registered)
- tc  out  1  terminal-count strobe (combinational)
- ovf  out  1  sticky overflow/underflow flag (registered)

## Operation

- Internal state: q register, prescaler register pre (width clog2(PRESCALE), absent when PRESCALE=1), ovf register.
- step = en && (pre == PRESCALE-1). For PRESCALE=1, step = en.
- boundary = up ? (q == MOD-1) : (q == 0).
- Priority per edge: reset > clr > load > step > hold.
- reset or clr: q ← 0, pre ← 0, ovf ← 0.
- load (no reset/clr): q ← d if d ≤ MOD-1, else q ← MOD-1. pre ← 0. ovf unchanged. en and up are ignored that cycle.
- en=1, no load/clr: pre ← (pre == PRESCALE-1) ? 0 : pre+1.
- step and not boundary: q ← q+1 (up) or q−1 (down).
- step and boundary, WRAP=1: q ← 0 (up) or MOD-1 (down). ovf ← 1.
- step and boundary, WRAP=0: q holds. ovf ← 1.
- en=0: q, pre and ovf hold.
- tc = step && boundary && !load && !clr && !reset. It marks the cycle whose edge performs the wrap or saturated step.
- Direction may change on any cycle. The boundary is evaluated with the current up value.
- All arithmetic is WIDTH bits plus one guard bit internally. The MOD-1 compare must be correct when MOD = 2^WIDTH.
- Parameter legality is checked at elaboration; illegal values are a fatal error.

## Timing

- Reset values: q=0, ovf=0, tc=0, pre=0.
- q and ovf update one cycle after the qualifying input, with no extra latency.
- tc is valid in the same cycle as its inputs, and is high for exactly one cycle per boundary step.
- With WRAP=0 held at the boundary, tc stays high on every step cycle.
- Steady-state step rate is one step per PRESCALE enabled cycles. Gaps in en stretch the period without losing prescaler phase.
- Reset asserted mid-count takes effect at the next edge, regardless of clr, load or en.
- Simultaneous load and boundary step: load wins, and neither tc nor ovf is asserted.

## Test plan

- Default parameters with MOD=100, reset, then en=1 up=1 for 101 cycles -> q runs 0..99 then 0. tc is high only in the cycle q==99. ovf reads 1 from the cycle q returns to 0.
- MOD=100, en=1 up=0 from q=0 -> next q=99 with tc high in the q==0 cycle, then 98, 97, … Toggle up at q=50 -> q goes to 51.
- load with d=42 -> q=42 next cycle. load with d=120 -> q=99. load and clr together -> q=0, ovf=0. load at q==99 with en=1 -> q=d, tc=0.
- PRESCALE=4, MOD=10, en=1 -> q increments every 4th cycle. Drop en for 3 cycles mid-phase -> q and pre freeze, and the phase resumes without loss. At q==9, tc pulses once per 4 cycles.
- WRAP=0, MOD=100, counting up -> q saturates at 99, tc high every step cycle, ovf=1. Switch up=0 -> q=98, and ovf stays 1 until clr.
- At q=57 with ovf=1 and pre=2 (PRESCALE=4), pulse reset for 1 cycle -> q=0, ovf=0, pre=0, tc=0. Counting restarts correctly afterwards.

Source files
------------

// File: rtl/counter_mod_updown.sv
// Bounded up/down counter with prescaler, parallel load, synchronous clear,
// wrap-or-saturate boundary behaviour, terminal-count strobe and sticky overflow.
module counter_mod_updown #(
  parameter int WIDTH    = 7,
  parameter int MOD      = 128,
  parameter int PRESCALE = 1,
  parameter int WRAP     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 31 || MOD < 2 || longint'(MOD) > (longint'(1) << WIDTH) ||
      PRESCALE < 1) begin : g_bad_param
    $fatal(1, "counter_mod_updown: illegal WIDTH/MOD/PRESCALE");
  end

  // Top count held with a guard bit so the compare stays exact at full range.
  localparam logic [WIDTH:0]   MAX   = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH-1:0] MAX_Q = MAX[WIDTH-1:0];

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             pre_last, step, boundary;

  if (PRESCALE > 1) begin : g_pre
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] pre_q, pre_d;

    // Phase only advances on enabled cycles, so gaps in en never lose phase.
    always_comb begin
      pre_d = pre_q;
      if (clr || load)  pre_d = '0;
      else if (en)      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    end

    always_ff @(posedge clk) begin
      if (reset) pre_q <= '0;
      else       pre_q <= pre_d;
    end

    assign pre_last = (pre_q == PRE_LAST);
  end else begin : g_nopre
    assign pre_last = 1'b1;
  end

  always_comb begin
    step     = en && pre_last;
    boundary = up ? ({1'b0, q_q} == MAX) : (q_q == '0);
    q_d      = q_q;
    ovf_d    = ovf_q;
    if (clr) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      q_d = ({1'b0, d} > MAX) ? MAX_Q : d;
    end else if (step) begin
      if (boundary) begin
        ovf_d = 1'b1;
        if (WRAP != 0) q_d = up ? '0 : MAX_Q;
      end else begin
        q_d = up ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;
  assign tc  = step && boundary && !load && !clr && !reset;

endmodule

// File: tb/tb_counter_mod_updown.sv
// Randomized bench: four counter configurations share stimulus and are each
// checked every cycle against an integer reference model.
module tb_counter_mod_updown;

  localparam int N = 4;
  localparam int MODS [N] = '{100, 10, 100, 128};
  localparam int PRES [N] = '{1, 4, 3, 1};
  localparam int WRAPS[N] = '{1, 1, 0, 1};

  logic clk = 1'b0;
  logic rst, clr, load, en, up;
  logic [6:0] d;
  logic [N-1:0][6:0] qo;
  logic [N-1:0] tco, ovo;

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;
  int mq[N]   = '{default: 0};
  int mpre[N] = '{default: 0};
  int mov[N]  = '{default: 0};
  int dv;

  always #5 clk = ~clk;

  counter_mod_updown #(.WIDTH(7), .MOD(100), .PRESCALE(1), .WRAP(1)) u_a (
    .clk(clk), .reset(rst), .clr(clr), .load(load), .d(d), .en(en), .up(up),
    .q(qo[0]), .tc(tco[0]), .ovf(ovo[0]));
  counter_mod_updown #(.WIDTH(7), .MOD(10), .PRESCALE(4), .WRAP(1)) u_b (
    .clk(clk), .reset(rst), .clr(clr), .load(load), .d(d), .en(en), .up(up),
    .q(qo[1]), .tc(tco[1]), .ovf(ovo[1]));
  counter_mod_updown #(.WIDTH(7), .MOD(100), .PRESCALE(3), .WRAP(0)) u_c (
    .clk(clk), .reset(rst), .clr(clr), .load(load), .d(d), .en(en), .up(up),
    .q(qo[2]), .tc(tco[2]), .ovf(ovo[2]));
  counter_mod_updown u_d (
    .clk(clk), .reset(rst), .clr(clr), .load(load), .d(d), .en(en), .up(up),
    .q(qo[3]), .tc(tco[3]), .ovf(ovo[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc_n, obs, exp);
    end
  endtask

  function automatic logic mdl_tc(input int i);
    logic at_edge;
    at_edge = up ? (mq[i] == MODS[i] - 1) : (mq[i] == 0);
    return en && (mpre[i] == PRES[i] - 1) && at_edge && !load && !clr && !rst;
  endfunction

  // Next state from the behavioural rules: counts live in 0..MOD-1 as plain ints.
  task automatic mdl_step();
    int nq;
    for (int i = 0; i < N; i++) begin
      if (rst || clr) begin
        mq[i] = 0; mpre[i] = 0; mov[i] = 0;
      end else if (load) begin
        mq[i]   = (dv > MODS[i] - 1) ? MODS[i] - 1 : dv;
        mpre[i] = 0;
      end else if (en) begin
        mpre[i] = (mpre[i] + 1) % PRES[i];
        if (mpre[i] == 0) begin
          nq = up ? mq[i] + 1 : mq[i] - 1;
          if (nq < 0 || nq >= MODS[i]) begin
            mov[i] = 1;
            if (WRAPS[i] != 0) mq[i] = (nq + MODS[i]) % MODS[i];
          end else begin
            mq[i] = nq;
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit r_, input bit c_, input bit l_, input int d_,
                     input bit e_, input bit u_);
    rst = r_; clr = c_; load = l_; dv = d_; d = 7'(d_); en = e_; up = u_;
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("tc[%0d]", i), 32'(tco[i]), 32'(mdl_tc(i)));
    @(posedge clk);
    mdl_step();
    cyc_n++;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("q[%0d]", i), 32'(qo[i]), 32'(mq[i]));
      chk($sformatf("ovf[%0d]", i), 32'(ovo[i]), 32'(mov[i]));
    end
  endtask

  initial begin
    bit ur;
    rst = 1'b1; clr = 1'b0; load = 1'b0; d = '0; dv = 0; en = 1'b0; up = 1'b1;
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 1, 5, 1, 1);
    // Up through the wrap, then long enough for the saturating copy to pin.
    repeat (101) cyc(0, 0, 0, 0, 1, 1);
    repeat (320) cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 0, 1);
    repeat (60) cyc(0, 0, 0, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 0, 1, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    repeat (6) cyc(0, 0, 0, 0, 1, 1);
    // Loads: in-range, clamped, with clr, and at the boundary with en.
    cyc(0, 0, 1, 42, 1, 0);
    cyc(0, 0, 1, 120, 0, 1);
    cyc(0, 0, 1, 127, 0, 1);
    cyc(0, 1, 1, 42, 1, 1);
    cyc(0, 0, 1, 99, 0, 1);
    cyc(0, 0, 1, 9, 1, 1);
    repeat (10) cyc(0, 0, 0, 0, 1, 1);
    cyc(1, 1, 1, 50, 1, 1);
    repeat (5) cyc(0, 0, 0, 0, 1, 0);
    // Random traffic with sticky direction so boundaries are actually reached.
    ur = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 19) == 0) ur = ~ur;
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 79) == 0,
          $urandom_range(0, 14) == 0, int'($urandom_range(0, 127)),
          $urandom_range(0, 9) != 0, ur);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
